neuron_mac: RTL

Multiply-accumulate neuron core that sits directly downstream of the per-neuron weight memory.
- For each input sample it drives the memory read port (ren/radd) and multiplies the sample by the returned weight.
- It accumulates numWeight products, adds the neuron bias, applies optional ReLU, and emits one saturated fixed-point result per input vector.
- The result feeds the layer's activation/output collection stage.

---
 rtl/neuron_mac_pkg.sv | 37 +++
 rtl/neuron_mac_sat_act.sv | 22 ++
 rtl/neuron_mac.sv | 126 ++++++++++++
 3 files changed

// File: rtl/neuron_mac_pkg.sv
// Shared Q-format constants and output-stage helpers for the neuron MAC.
// The helpers work on fixed maximum widths so they serve any legal parameterisation.
package neuron_mac_pkg;

    localparam int unsigned DataWidth    = 16;
    localparam int unsigned FracBits     = 8;
    localparam int unsigned MaxAccWidth  = 64;
    localparam int unsigned MaxDataWidth = 32;

    // Arithmetic shift (floor) followed by a clamp to a dw-bit signed range.
    function automatic logic signed [MaxDataWidth-1:0] sat_trunc(
        input logic signed [MaxAccWidth-1:0] sum,
        input int unsigned                   dw,
        input int unsigned                   fb
    );
        logic signed [MaxAccWidth-1:0] res;
        logic signed [MaxAccWidth-1:0] hi;
        logic signed [MaxAccWidth-1:0] lo;
        res = sum >>> fb;
        hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (dw - 1));
        if (res > hi) begin
            res = hi;
        end else if (res < lo) begin
            res = lo;
        end
        return res[MaxDataWidth-1:0];
    endfunction

    function automatic logic signed [MaxDataWidth-1:0] relu_clamp(
        input logic signed [MaxDataWidth-1:0] v,
        input bit                             en
    );
        return (en && (v < 0)) ? '0 : v;
    endfunction

endpackage

// File: rtl/neuron_mac_sat_act.sv
// Combinational output stage: full-precision sum in, saturated and optionally
// ReLU-clamped fixed-point result out.
module neuron_mac_sat_act
    import neuron_mac_pkg::*;
#(
    parameter int unsigned accWidth  = 40,
    parameter int unsigned dataWidth = DataWidth,
    parameter int unsigned fracBits  = FracBits,
    parameter int unsigned actRelu   = 0
) (
    input  logic [accWidth-1:0]  i_sum,
    output logic [dataWidth-1:0] o_res
);

    logic [MaxAccWidth-1:0] w_sum_ext;

    assign w_sum_ext = {{(MaxAccWidth - accWidth){i_sum[accWidth-1]}}, i_sum};

    assign o_res = dataWidth'(relu_clamp(sat_trunc($signed(w_sum_ext), dataWidth, fracBits),
                                         actRelu != 0));

endmodule

// File: rtl/neuron_mac.sv
// Multiply-accumulate neuron: reads one weight per input sample, accumulates
// numWeight products plus bias, and emits one saturated result per vector.
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int unsigned numWeight    = 3,
    parameter int unsigned addressWidth = 10,
    parameter int unsigned dataWidth    = DataWidth,
    parameter int unsigned fracBits     = FracBits,
    parameter int unsigned accWidth     = 40,
    parameter int unsigned actRelu      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [dataWidth-1:0]    in_data,
    input  logic [dataWidth-1:0]    bias,
    output logic                    ren,
    output logic [addressWidth-1:0] radd,
    input  logic [dataWidth-1:0]    wout,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data
);

    logic [addressWidth-1:0]  r_wcnt;
    logic                     r_a_v;
    logic                     r_a_last;
    logic [dataWidth-1:0]     r_x;
    logic                     r_b_v;
    logic                     r_b_last;
    logic [2*dataWidth-1:0]   r_prod;
    logic [accWidth-1:0]      r_acc;
    logic                     r_out_valid;
    logic [dataWidth-1:0]     r_out_data;

    logic                     w_last;
    logic [2*dataWidth-1:0]   w_x_ext;
    logic [2*dataWidth-1:0]   w_w_ext;
    logic [2*dataWidth-1:0]   w_prod;
    logic [accWidth-1:0]      w_prod_ext;
    logic [accWidth-1:0]      w_bias_ext;
    logic [accWidth-1:0]      w_acc_sum;
    logic [accWidth-1:0]      w_final_sum;
    logic [dataWidth-1:0]     w_res;

    assign ren    = in_valid;
    assign radd   = r_wcnt;
    assign w_last = (r_wcnt == addressWidth'(numWeight - 1));

    // Low 2*dataWidth bits of a product of sign-extended operands equal the signed product.
    assign w_x_ext = {{dataWidth{r_x[dataWidth-1]}}, r_x};
    assign w_w_ext = {{dataWidth{wout[dataWidth-1]}}, wout};
    assign w_prod  = w_x_ext * w_w_ext;

    assign w_prod_ext  = {{(accWidth - 2*dataWidth){r_prod[2*dataWidth-1]}}, r_prod};
    assign w_bias_ext  = {{(accWidth - dataWidth - fracBits){bias[dataWidth-1]}}, bias,
                          {fracBits{1'b0}}};
    assign w_acc_sum   = r_acc + w_prod_ext;
    assign w_final_sum = w_acc_sum + w_bias_ext;

    neuron_mac_sat_act #(
        .accWidth  (accWidth),
        .dataWidth (dataWidth),
        .fracBits  (fracBits),
        .actRelu   (actRelu)
    ) u_sat_act (
        .i_sum (w_final_sum),
        .o_res (w_res)
    );

    // Stage A: sample capture and weight address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt   <= '0;
            r_a_v    <= 1'b0;
            r_a_last <= 1'b0;
            r_x      <= '0;
        end else begin
            r_a_v <= in_valid;
            if (in_valid) begin
                r_x      <= in_data;
                r_a_last <= w_last;
                r_wcnt   <= w_last ? '0 : r_wcnt + 1'b1;
            end
        end
    end

    // Stage B: multiply by the weight returned for the previous cycle's read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_v    <= 1'b0;
            r_b_last <= 1'b0;
            r_prod   <= '0;
        end else begin
            r_b_v    <= r_a_v;
            r_b_last <= r_a_last;
            if (r_a_v) begin
                r_prod <= w_prod;
            end
        end
    end

    // Stage C: accumulate; on the last product fold in bias, emit and clear in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_b_v) begin
                if (r_b_last) begin
                    r_out_data  <= w_res;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                end else begin
                    r_acc <= w_acc_sum;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
